// File: rtl/sfft_readout_pkg.sv
// -----------------------------------------------------------------------------
// sfft_readout_pkg
// Shared definitions for the SFFT readout controller:
//   - state_e           : controller state encoding
//   - DEF_NFFT_LOG2     : default log2 of the bin count
//   - DEF_FRAME_CNT_W   : default frame counter width
//   - COUNT_BASE        : byte address of the frame counter (4 bytes)
//   - BIN_BASE          : byte address of front-bank word 0
//   - status_offset()   : byte address of the status byte for a given size
//   - TEST_PATTERN      : upper half-word written in test-pattern builds
// -----------------------------------------------------------------------------
package sfft_readout_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StPublish = 2'd2
    } state_e;

    localparam int unsigned DEF_NFFT_LOG2   = 7;
    localparam int unsigned DEF_FRAME_CNT_W = 32;

    localparam int unsigned COUNT_BASE = 0;
    localparam int unsigned BIN_BASE   = 4;

    localparam logic [15:0] TEST_PATTERN = 16'hA5A5;

    // Status byte sits right after the last bin word.
    function automatic int unsigned status_offset(input int unsigned nfft_log2);
        return BIN_BASE + 4 * (32'd1 << nfft_log2);
    endfunction

    localparam int unsigned DEF_STATUS_OFFSET = status_offset(DEF_NFFT_LOG2);

endpackage

// File: rtl/readout_bank_ram.sv
// -----------------------------------------------------------------------------
// readout_bank_ram
// Two banks of 2**IDX_W 32-bit words. One synchronous write port and one
// synchronous read port, each addressed by (bank, index). Contents are not
// reset.
// Ports:
//   i_clk       clock
//   i_wr_en     write enable
//   i_wr_bank   write bank select
//   i_wr_idx    write word index
//   i_wr_data   write data
//   i_rd_bank   read bank select
//   i_rd_idx    read word index
//   o_rd_data   read data, one cycle after the read address
// -----------------------------------------------------------------------------
module readout_bank_ram #(
    parameter int unsigned IDX_W = 7
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic             i_wr_bank,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data,
    input  logic             i_rd_bank,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data
);

    localparam int unsigned DEPTH = 2 * (32'd1 << IDX_W);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_idx}] <= i_wr_data;
        end
        r_rd_data <= r_mem[{i_rd_bank, i_rd_idx}];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sfft_readout_ctrl.sv
// -----------------------------------------------------------------------------
// sfft_readout_ctrl
// Captures one SFFT frame per rising edge of sfft_valid into the back bank of
// a double-buffered RAM, then publishes it by swapping banks once software is
// not reading. Software reads bytes of the front bank, the frame counter and a
// status byte through a registered byte port.
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   sfft_valid      SFFT output-valid level; rising edge starts a frame
//   output_address  bin index driven to the SFFT output memory
//   sfft_out        bin amplitude, valid one cycle after output_address
//   chipselect      high while software reads a frame
//   address         software byte address
//   readdata        read byte, one cycle after address
//   frame_count     number of published frames
//   busy            high whenever not idle
//   overrun         sticky: a frame start was dropped
// Build option: define READOUT_TESTPATTERN_EN to store {16'hA5A5, k} in word k
// instead of sfft_out (timing unchanged).
// -----------------------------------------------------------------------------
module sfft_readout_ctrl
    import sfft_readout_pkg::*;
#(
    parameter int unsigned NFFT_LOG2   = DEF_NFFT_LOG2,
    parameter int unsigned FRAME_CNT_W = DEF_FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sfft_valid,
    output logic [NFFT_LOG2-1:0]   output_address,
    input  logic [31:0]            sfft_out,
    input  logic                   chipselect,
    input  logic [15:0]            address,
    output logic [7:0]             readdata,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned        N          = 32'd1 << NFFT_LOG2;
    localparam int unsigned        STATUS_OFF = status_offset(NFFT_LOG2);
    localparam logic [NFFT_LOG2:0] LAST_CNT   = (NFFT_LOG2 + 1)'(N);

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_armed;
    logic                   r_valid_prev;
    logic [NFFT_LOG2:0]     r_cnt;
    logic [NFFT_LOG2:0]     w_cnt_next;
    logic                   r_wr_en;
    logic [NFFT_LOG2-1:0]   r_wr_idx;
    logic                   r_bank;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_overrun;
    logic                   r_rd_bin;
    logic [1:0]             r_rd_lane;
    logic [7:0]             r_misc_byte;

    logic                   w_edge;
    logic                   w_swap;
    logic                   w_capture_addr;
    logic                   w_overrun_set;
    logic                   w_status_rd;
    logic [31:0]            w_wr_data;
    logic [31:0]            w_ram_rd;
    int unsigned            w_addr;
    logic                   w_bin_sel;
    logic [NFFT_LOG2-1:0]   w_bin_idx;
    logic [31:0]            w_count32;
    logic [7:0]             w_misc_byte;

    // r_armed masks the first cycle after reset so a level already high at
    // release is not mistaken for a new frame.
    assign w_edge        = r_armed & sfft_valid & ~r_valid_prev;
    assign w_overrun_set = w_edge & (r_state != StIdle);
    assign w_status_rd   = chipselect & (address == 16'(STATUS_OFF));

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_swap         = 1'b0;
        w_capture_addr = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (w_edge) begin
                    w_state_next = StCapture;
                end
            end
            StCapture: begin
                // Extra cycle at r_cnt == N lets the last write land first.
                if (r_cnt == LAST_CNT) begin
                    w_state_next = StPublish;
                end else begin
                    w_capture_addr = 1'b1;
                    w_cnt_next     = r_cnt + (NFFT_LOG2 + 1)'(1);
                end
            end
            StPublish: begin
                if (!chipselect) begin
                    w_swap       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign output_address = w_capture_addr ? r_cnt[NFFT_LOG2-1:0] : '0;

`ifdef READOUT_TESTPATTERN_EN
    assign w_wr_data = {TEST_PATTERN, 16'(r_wr_idx)};
`else
    assign w_wr_data = sfft_out;
`endif

    // Read decode. Bin bytes come from the RAM's registered output; all other
    // sources are resolved now and registered in r_misc_byte.
    assign w_addr    = 32'(address);
    assign w_bin_sel = (w_addr >= BIN_BASE) && (w_addr < STATUS_OFF);
    assign w_bin_idx = NFFT_LOG2'((w_addr - BIN_BASE) >> 2);
    assign w_count32 = 32'(r_frame_count);

    always_comb begin
        w_misc_byte = 8'h00;
        if (w_addr < COUNT_BASE + 4) begin
            w_misc_byte = w_count32[{address[1:0], 3'b000} +: 8];
        end else if (w_addr == STATUS_OFF) begin
            w_misc_byte = {6'b0, r_overrun, (r_state != StIdle)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_armed       <= 1'b0;
            r_valid_prev  <= 1'b0;
            r_cnt         <= '0;
            r_wr_en       <= 1'b0;
            r_wr_idx      <= '0;
            r_bank        <= 1'b0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
            r_rd_bin      <= 1'b0;
            r_rd_lane     <= 2'b00;
            r_misc_byte   <= 8'h00;
        end else begin
            r_state      <= w_state_next;
            r_armed      <= 1'b1;
            r_valid_prev <= sfft_valid;
            r_cnt        <= w_cnt_next;
            r_wr_en      <= w_capture_addr;
            r_wr_idx     <= r_cnt[NFFT_LOG2-1:0];
            if (w_swap) begin
                r_bank        <= ~r_bank;
                r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            end
            // A new overrun in the same cycle as a status read wins.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_status_rd) begin
                r_overrun <= 1'b0;
            end
            r_rd_bin    <= w_bin_sel;
            r_rd_lane   <= address[1:0];
            r_misc_byte <= w_misc_byte;
        end
    end

    readout_bank_ram #(
        .IDX_W (NFFT_LOG2)
    ) u_bank_ram (
        .i_clk     (clk),
        .i_wr_en   (r_wr_en),
        .i_wr_bank (~r_bank),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (w_wr_data),
        .i_rd_bank (r_bank),
        .i_rd_idx  (w_bin_idx),
        .o_rd_data (w_ram_rd)
    );

    assign readdata    = r_rd_bin ? w_ram_rd[{r_rd_lane, 3'b000} +: 8] : r_misc_byte;
    assign frame_count = r_frame_count;
    assign busy        = (r_state != StIdle);
    assign overrun     = r_overrun;

endmodule
